// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with blanking and blink.
// Ports:
//   clk, rst_n     - clock and synchronous active-low reset
//   en             - scan enable; low blanks the display and freezes the scan
//   digit0..digit3 - BCD digit values for positions 0..3
//   blink_mask     - per-digit blink enable
//   dp_mask        - per-digit decimal point enable
//   sel            - current slot index (drives the external digit mux)
//   an, seg, dp    - registered active-low anode, segment, decimal-point drives
//   frame_tick     - one-cycle pulse after each completed 4-slot frame
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYC    = 1000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] blink_mask,
    input  logic [3:0] dp_mask,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LIT = DIV_W'(BLANK_CYC);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;

    logic [3:0] cur_digit;
    logic [6:0] cur_seg;
    logic       lit;
    logic [3:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;

    // Select the digit for the active slot and decode it.
    always_comb begin
        cur_digit = digit0;
        unique case (sel)
            2'd0: cur_digit = digit0;
            2'd1: cur_digit = digit1;
            2'd2: cur_digit = digit2;
            2'd3: cur_digit = digit3;
        endcase

        cur_seg = 7'h7F;
        case (cur_digit)
            4'd0:    cur_seg = 7'h40;
            4'd1:    cur_seg = 7'h79;
            4'd2:    cur_seg = 7'h24;
            4'd3:    cur_seg = 7'h30;
            4'd4:    cur_seg = 7'h19;
            4'd5:    cur_seg = 7'h12;
            4'd6:    cur_seg = 7'h02;
            4'd7:    cur_seg = 7'h78;
            4'd8:    cur_seg = 7'h00;
            4'd9:    cur_seg = 7'h10;
            default: cur_seg = 7'h7F;
        endcase
    end

    // The first BLANK_CYC cycles of each slot stay dark to hide ghosting
    // while the external digit mux settles.
    always_comb begin
        lit   = en && (div_cnt >= DIV_LIT)
                && !(blink_mask[sel] && blink_phase);
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (lit) begin
            an_d  = ~(4'b0001 << sel);
            seg_d = cur_seg;
            dp_d  = ~dp_mask[sel];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            sel         <= 2'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_tick  <= 1'b0;
            an          <= 4'b1111;
            seg         <= 7'h7F;
            dp          <= 1'b1;
        end else begin
            frame_tick <= 1'b0;
            if (en) begin
                if (div_cnt == DIV_MAX) begin
                    div_cnt    <= '0;
                    sel        <= sel + 2'd1;
                    frame_tick <= (sel == 2'd3);
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            // A frame pulse that has already been issued is always counted.
            if (frame_tick) begin
                if (blink_cnt == BLK_MAX) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a
// count-based reference model (REFRESH_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2).
module tb_seg_scan_driver;

    localparam int R  = 4;
    localparam int BC = 1;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] blink_mask, dp_mask;
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    seg_scan_driver #(
        .REFRESH_DIV (R),
        .BLANK_CYC   (BC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digit0    (digit0),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .blink_mask(blink_mask),
        .dp_mask   (dp_mask),
        .sel       (sel),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: n = enabled cycles since reset, frames = frame pulses counted.
    int n      = 0;
    int frames = 0;
    bit tick   = 1'b0;
    int ticks_seen;

    int dec_tab[16];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic int m_sel();
        return (n / R) % 4;
    endfunction

    function automatic bit m_phase();
        return ((frames / BF) % 2) == 1;
    endfunction

    task automatic step();
        int s;
        int dg;
        int e_an, e_seg, e_dp;
        bit lit;
        s = m_sel();
        case (s)
            0:       dg = int'(digit0);
            1:       dg = int'(digit1);
            2:       dg = int'(digit2);
            default: dg = int'(digit3);
        endcase
        lit = rst_n && en && ((n % R) >= BC)
              && !(blink_mask[s] && m_phase());
        if (lit) begin
            e_an  = 15 ^ (1 << s);
            e_seg = dec_tab[dg];
            e_dp  = dp_mask[s] ? 0 : 1;
        end else begin
            e_an  = 15;
            e_seg = 127;
            e_dp  = 1;
        end
        if (!rst_n) begin
            n      = 0;
            frames = 0;
            tick   = 1'b0;
        end else begin
            frames = frames + (tick ? 1 : 0);
            if (en) begin
                n    = n + 1;
                tick = (n % (4 * R)) == 0;
            end else begin
                tick = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("sel", int'(sel), m_sel());
        check("frame_tick", int'(frame_tick), int'(tick));
        check("an", int'(an), e_an);
        check("seg", int'(seg), e_seg);
        check("dp", int'(dp), e_dp);
        check("an_onehot", int'($countones(~an) <= 1), 1);
        if (frame_tick) ticks_seen++;
    endtask

    initial begin
        dec_tab = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                    'h00, 'h10, 'h7F, 'h7F, 'h7F, 'h7F, 'h7F, 'h7F};
        rst_n = 1'b0; en = 1'b0;
        digit0 = 4'd1; digit1 = 4'd2; digit2 = 4'd3; digit3 = 4'd4;
        blink_mask = 4'b0000; dp_mask = 4'b0000;
        repeat (3) step();

        // Basic scan with digits 1,2,3,4 over one full frame.
        rst_n = 1'b1; en = 1'b1;
        ticks_seen = 0;
        repeat (16) step();
        check("ticks_in_16", ticks_seen, 1);
        repeat (4) step();

        // Blink on digit 1 over several blink phases.
        blink_mask = 4'b0010;
        repeat (96) step();
        blink_mask = 4'b0000;

        // Non-BCD digit blanks its segments but keeps the decimal point.
        digit2 = 4'hC; dp_mask = 4'b0100;
        repeat (16) step();
        dp_mask = 4'b0000;

        // Freeze mid-slot 1, then resume.
        for (int i = 0; i < 64 && (n % 16) != 5; i++) step();
        check("reach_slot1", n % 16, 5);
        en = 1'b0;
        repeat (10) step();
        en = 1'b1;
        repeat (16) step();

        // Reset during slot 3 while the blink phase is set.
        blink_mask = 4'b1000;
        for (int i = 0; i < 400 && !(m_sel() == 3 && m_phase()); i++) step();
        check("reach_slot3_ph1", int'(m_sel() == 3 && m_phase()), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (20) step();

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            digit0 = 4'($urandom_range(0, 15));
            digit1 = 4'($urandom_range(0, 15));
            digit2 = 4'($urandom_range(0, 15));
            digit3 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) begin
                blink_mask = 4'($urandom);
                dp_mask    = 4'($urandom);
            end
            en    = $urandom_range(0, 9) != 0;
            rst_n = $urandom_range(0, 199) != 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
